// File: rtl/ucode_sequencer_pkg.sv
// Shared CPU types for the micro-code sequencer: flag bundle, condition codes and sequencer states.
package ucode_sequencer_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    COND_NZ = 2'd0,
    COND_Z  = 2'd1,
    COND_NC = 2'd2,
    COND_C  = 2'd3
  } cond_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_IRQ  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ucode_sequencer_cond_eval.sv
// Combinational branch-condition evaluator: matched_o is high when cond_i holds for flags_i.
module cond_eval
  import ucode_sequencer_pkg::*;
(
  input  cond_t  cond_i,
  input  flags_t flags_i,
  output logic   matched_o
);

  always_comb begin
    matched_o = 1'b0;
    unique case (cond_i)
      COND_NZ: matched_o = ~flags_i.z;
      COND_Z:  matched_o =  flags_i.z;
      COND_NC: matched_o = ~flags_i.c;
      COND_C:  matched_o =  flags_i.c;
      default: matched_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Micro-code step sequencer with RUN/HALT/IRQ states, prefix-opcode handling and a sticky step overflow flag.
// Interrupt entry is built only when SEQ_IRQ_EN is defined; otherwise irq_req merely wakes HALT into RUN.
module ucode_sequencer
  import ucode_sequencer_pkg::*;
#(
  parameter int                STEP_W    = 3,
  parameter int                IR_W      = 8,
  parameter logic [IR_W-1:0]   PREFIX_OP = 8'hCB,
  parameter logic [IR_W-1:0]   HALT_OP   = 8'h76
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              done,
  input  logic              is_cond,
  input  logic [1:0]        cond,
  input  logic [3:0]        flags,
  input  logic [STEP_W-1:0] next_cond,
  input  logic [IR_W-1:0]   d_in,
  input  logic              irq_req,
  input  logic              ime,
  output logic [IR_W-1:0]   ir,
  output logic [STEP_W-1:0] step,
  output logic              in_prefix,
  output logic              in_irq,
  output logic              halted,
  output logic              step_ovf
);

  seq_state_t        state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              pre_q, pre_d;
  logic              ovf_q, ovf_d;

  logic              matched;
  logic              irq_take;
  logic [STEP_W-1:0] adv_step;
  logic              adv_ovf;

  cond_eval u_cond_eval (
    .cond_i    (cond_t'(cond)),
    .flags_i   (flags_t'(flags)),
    .matched_o (matched)
  );

`ifdef SEQ_IRQ_EN
  assign irq_take = irq_req & ime;
`else
  logic unused_ime;
  assign unused_ime = ime;
  assign irq_take   = 1'b0;
`endif

  // Step advance shared by RUN and IRQ: a failed condition jumps, anything else increments and may wrap.
  always_comb begin
    adv_step = step_q + 1'b1;
    adv_ovf  = 1'b0;
    if (is_cond && !matched) begin
      adv_step = next_cond;
    end else if (step_q == {STEP_W{1'b1}}) begin
      adv_step = '0;
      adv_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ir_q    <= '0;
      step_q  <= '0;
      pre_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    step_d  = step_q;
    pre_d   = pre_q;
    ovf_d   = ovf_q;
    if (!stall) begin
      unique case (state_q)
        ST_RUN: begin
          if (done) begin
            if (irq_take) begin
              state_d = ST_IRQ;
              step_d  = '0;
            end else if (ir_q == HALT_OP && !pre_q) begin
              state_d = ST_HALT;
              step_d  = '0;
            end else begin
              ir_d   = d_in;
              step_d = '0;
              pre_d  = 1'b0;
            end
          end else if (ir_q == PREFIX_OP && !pre_q && step_q == '0) begin
            // The second opcode byte replaces the prefix in one cycle; step stays at 0.
            ir_d  = d_in;
            pre_d = 1'b1;
          end else begin
            step_d = adv_step;
            ovf_d  = ovf_q | adv_ovf;
          end
        end
        ST_HALT: begin
          if (irq_req) begin
            step_d = '0;
            if (irq_take) begin
              state_d = ST_IRQ;
            end else begin
              state_d = ST_RUN;
              ir_d    = d_in;
            end
          end
        end
        ST_IRQ: begin
          if (done) begin
            state_d = ST_RUN;
            ir_d    = d_in;
            step_d  = '0;
            pre_d   = 1'b0;
          end else begin
            step_d = adv_step;
            ovf_d  = ovf_q | adv_ovf;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    halted = (state_q == ST_HALT);
`ifdef SEQ_IRQ_EN
    in_irq = (state_q == ST_IRQ);
`else
    in_irq = 1'b0;
`endif
  end

  assign ir        = ir_q;
  assign step      = step_q;
  assign in_prefix = pre_q;
  assign step_ovf  = ovf_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios then random traffic, every cycle checked against a reference model.
module tb_ucode_sequencer;

  localparam int STEP_W = 3;
  localparam int IR_W   = 8;
  localparam int STEP_MOD = 1 << STEP_W;
  localparam int PREFIX = 'hCB;
  localparam int HALTOP = 'h76;
`ifdef SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // model modes
  localparam int M_RUN = 0, M_HALT = 1, M_IRQ = 2;

  logic              clk = 1'b0;
  logic              rst, stall, done, is_cond, irq_req, ime;
  logic [1:0]        cond;
  logic [3:0]        flags;
  logic [STEP_W-1:0] next_cond;
  logic [IR_W-1:0]   d_in;
  logic [IR_W-1:0]   ir;
  logic [STEP_W-1:0] step;
  logic              in_prefix, in_irq, halted, step_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mode, m_ir, m_step, m_pre, m_ovf;

  ucode_sequencer #(.STEP_W(STEP_W), .IR_W(IR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .done(done), .is_cond(is_cond),
    .cond(cond), .flags(flags), .next_cond(next_cond), .d_in(d_in),
    .irq_req(irq_req), .ime(ime), .ir(ir), .step(step), .in_prefix(in_prefix),
    .in_irq(in_irq), .halted(halted), .step_ovf(step_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit cond_holds();
    case (cond)
      2'd0: return !flags[3];
      2'd1: return  flags[3];
      2'd2: return !flags[0];
      default: return flags[0];
    endcase
  endfunction

  task automatic model_advance();
    if (is_cond && !cond_holds()) m_step = int'(next_cond);
    else begin
      if (m_step + 1 >= STEP_MOD) m_ovf = 1;
      m_step = (m_step + 1) % STEP_MOD;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_mode = M_RUN; m_ir = 0; m_step = 0; m_pre = 0; m_ovf = 0;
    end else if (!stall) begin
      case (m_mode)
        M_RUN:
          if (done) begin
            if (IRQ_EN && irq_req && ime) begin m_mode = M_IRQ; m_step = 0; end
            else if (m_ir == HALTOP && m_pre == 0) begin m_mode = M_HALT; m_step = 0; end
            else begin m_ir = int'(d_in); m_step = 0; m_pre = 0; end
          end else if (m_ir == PREFIX && m_pre == 0 && m_step == 0) begin
            m_ir = int'(d_in); m_pre = 1;
          end else model_advance();
        M_HALT:
          if (irq_req) begin
            m_step = 0;
            if (IRQ_EN && ime) m_mode = M_IRQ;
            else begin m_mode = M_RUN; m_ir = int'(d_in); end
          end
        default:
          if (done) begin m_mode = M_RUN; m_ir = int'(d_in); m_step = 0; m_pre = 0; end
          else model_advance();
      endcase
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check("ir",        32'(ir),        32'(m_ir));
    check("step",      32'(step),      32'(m_step));
    check("in_prefix", 32'(in_prefix), 32'(m_pre));
    check("in_irq",    32'(in_irq),    32'(m_mode == M_IRQ));
    check("halted",    32'(halted),    32'(m_mode == M_HALT));
    check("step_ovf",  32'(step_ovf),  32'(m_ovf));
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; done = 0; is_cond = 0; irq_req = 0; ime = 0;
    cond = 2'd0; flags = 4'h0; next_cond = '0; d_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    idle_inputs();
    m_mode = M_RUN; m_ir = 0; m_step = 0; m_pre = 0; m_ovf = 0;
    #2;
    do_reset();

    // opcode fetch after reset
    done = 1; d_in = 8'h3E; tick(); done = 0;
    check("fetch_3e", 32'(ir), 32'h3E);

    // prefix sequence
    done = 1; d_in = 8'hCB; tick(); done = 0;
    d_in = 8'h37; tick();
    check("prefix_set", 32'(in_prefix), 32'd1);
    d_in = 8'h00; tick();
    done = 1; tick(); done = 0;
    check("prefix_clr", 32'(in_prefix), 32'd0);

    // conditional step: fail jumps, pass increments
    is_cond = 1; cond = 2'd1; flags = 4'h0; next_cond = 3'd3; tick();
    check("cond_fail", 32'(step), 32'd3);
    is_cond = 0; done = 1; tick(); done = 0;
    is_cond = 1; flags = 4'h8; tick(); is_cond = 0; flags = 4'h0;
    check("cond_pass", 32'(step), 32'd1);

    // halt, hold, wake
    done = 1; d_in = 8'h76; tick(); tick(); done = 0;
    check("halt_enter", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    irq_req = 1; ime = 1; d_in = 8'h12; tick(); irq_req = 0; ime = 0;
    tick(); tick();
    done = 1; d_in = 8'h21; tick(); done = 0;

    // stall freezes everything
    stall = 1; done = 1; d_in = 8'h55;
    for (int i = 0; i < 3; i++) tick();
    stall = 0; done = 0;

    // reset in the middle of an IRQ (or of a plain instruction)
    done = 1; irq_req = 1; ime = 1; tick(); done = 0; irq_req = 0; ime = 0;
    tick(); tick();
    stall = 1; done = 1; rst = 1; tick(); rst = 0; stall = 0; done = 0;
    check("rst_mid", 32'({ir, step, in_irq, halted}), 32'd0);

    // step overflow wraps and sticks
    for (int i = 0; i < STEP_MOD; i++) tick();
    check("ovf_set", 32'(step_ovf), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    done = 1; tick(); done = 0;
    check("ovf_sticky", 32'(step_ovf), 32'd1);
    do_reset();
    check("ovf_clr", 32'(step_ovf), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      done      = ($urandom_range(0, 4) == 0);
      is_cond   = ($urandom_range(0, 2) == 0);
      cond      = 2'($urandom_range(0, 3));
      flags     = 4'($urandom_range(0, 15));
      next_cond = STEP_W'($urandom_range(0, STEP_MOD - 1));
      irq_req   = ($urandom_range(0, 5) == 0);
      ime       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: d_in = 8'hCB;
        1: d_in = 8'h76;
        default: d_in = 8'($urandom_range(0, 255));
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
